// File: rtl/wts_wave_ram.sv
// Wave-table sample RAM: CH_NUM x WAVE_LEN x DATA_W single-port array shared by a
// real-time engine read port (fixed 1-cycle latency) and a req/ack CPU port, with auto-clear.
module wts_wave_ram #(
  parameter int DATA_W   = 8,
  parameter int CH_NUM   = 12,
  parameter int WAVE_LEN = 32,
  localparam int CH_W    = $clog2(CH_NUM),
  localparam int IDX_W   = $clog2(WAVE_LEN)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              clear_req,
  output logic              busy,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [CH_W-1:0]   cpu_ch,
  input  logic [IDX_W-1:0]  cpu_idx,
  input  logic [DATA_W-1:0] cpu_d,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_q,
  input  logic              en_req,
  input  logic [CH_W-1:0]   en_ch,
  input  logic [IDX_W-1:0]  en_idx,
  output logic              en_valid,
  output logic [DATA_W-1:0] en_q
);
  localparam int DEPTH  = CH_NUM * WAVE_LEN;
  localparam int ADDR_W = CH_W + IDX_W;

  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0]   cpu_q_q, cpu_q_d;
  logic                en_valid_q, en_valid_d;
  logic [DATA_W-1:0]   en_q_q, en_q_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   acc_addr;
  logic                acc_ok;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wd;
  logic [DATA_W-1:0]   rdata;
  logic                clearing;
  logic                cpu_gnt;

  // WAVE_LEN is a power of two, so ch*WAVE_LEN+idx is a plain concatenation.
  function automatic logic ch_ok(input logic [CH_W-1:0] ch);
    return {1'b0, ch} < (CH_W+1)'(CH_NUM);
  endfunction

  always_comb begin
    clearing = (state_q == S_CLEAR);
    // Ack cycle is a forced turnaround so the CPU never gets back-to-back slots.
    cpu_gnt  = !clearing && cpu_req && !en_req && !cpu_ack_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_addr = {cpu_ch, cpu_idx};
    acc_ok   = ch_ok(cpu_ch);
    mem_we   = 1'b0;
    mem_wd   = cpu_d;
    if (clearing) begin
      acc_addr = cnt_q;
      acc_ok   = 1'b1;
      mem_we   = 1'b1;
      mem_wd   = '0;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end else begin
      if (en_req) begin
        acc_addr = {en_ch, en_idx};
        acc_ok   = ch_ok(en_ch);
      end else if (cpu_gnt) begin
        mem_we = cpu_we && acc_ok;
      end
      if (clear_req) begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    end
    // Out-of-range channels never touch the array and read as zero.
    rdata      = (acc_ok && !mem_we) ? mem[acc_addr] : '0;
    en_valid_d = en_req;
    en_q_d     = en_req ? (clearing ? '0 : rdata) : en_q_q;
    cpu_ack_d  = cpu_gnt;
    cpu_q_d    = (cpu_gnt && !cpu_we) ? rdata : cpu_q_q;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_addr] <= mem_wd;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_CLEAR;
      cnt_q      <= '0;
      cpu_ack_q  <= 1'b0;
      cpu_q_q    <= '0;
      en_valid_q <= 1'b0;
      en_q_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cpu_ack_q  <= cpu_ack_d;
      cpu_q_q    <= cpu_q_d;
      en_valid_q <= en_valid_d;
      en_q_q     <= en_q_d;
    end
  end

  assign busy     = (state_q == S_CLEAR);
  assign cpu_ack  = cpu_ack_q;
  assign cpu_q    = cpu_q_q;
  assign en_valid = en_valid_q;
  assign en_q     = en_q_q;
endmodule
